// File: rtl/reg_file_pkg.sv
// Shared types and default widths for the clocked register file.
package reg_file_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 4;

endpackage

// File: rtl/reg_file_if.sv
// Write/read/clear bus of the register file; master drives requests, slave returns data.
interface reg_file_if
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr_1;
  logic [ADDR_W-1:0] rd_addr_2;
  logic [DATA_W-1:0] rd_data_1;
  logic [DATA_W-1:0] rd_data_2;
  logic              clr_req;
  logic              busy;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_1, rd_addr_2, clr_req,
    input  rd_data_1, rd_data_2, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_1, rd_addr_2, clr_req,
    output rd_data_1, rd_data_2, busy
  );

endinterface

// File: rtl/reg_file_clr_seq.sv
// Clear sequencer: sweeps every address once after reset or an accepted clear request.
module reg_file_clr_seq
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_req_i,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o,
  output logic              busy_o
);

  localparam logic [ADDR_W-1:0] LAST = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      CLEAR: begin
        // Pointer parks on the last address rather than wrapping.
        if (ptr_q == LAST) state_d = IDLE;
        else               ptr_d   = ptr_q + 1'b1;
      end
      IDLE: begin
        if (clr_req_i) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  assign clr_we_o   = (state_q == CLEAR);
  assign clr_addr_o = ptr_q;
  assign busy_o     = (state_q == CLEAR);

endmodule

// File: rtl/reg_file.sv
// Register file with one write port, two registered read ports, optional bypass and hard-zero r0.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter bit          BYPASS  = 1'b1,
  parameter bit          ZERO_R0 = 1'b0
) (
  input logic       clk,
  input logic       rst,
  reg_file_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
  logic              clr_we, busy, wr_ok;
  logic [ADDR_W-1:0] clr_addr;

  reg_file_clr_seq #(
    .ADDR_W (ADDR_W)
  ) u_clr_seq (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_req_i  (bus.clr_req),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr),
    .busy_o     (busy)
  );

  // A clear request in the same cycle wins over the write.
  assign wr_ok = !busy && bus.wr_en && !bus.clr_req &&
                 !(ZERO_R0 && (bus.wr_addr == '0));

  always_ff @(posedge clk) begin
    if (clr_we)     regs_q[clr_addr]    <= '0;
    else if (wr_ok) regs_q[bus.wr_addr] <= bus.wr_data;
  end

  always_comb begin
    rd1_d = regs_q[bus.rd_addr_1];
    if (BYPASS && wr_ok && (bus.wr_addr == bus.rd_addr_1)) rd1_d = bus.wr_data;
    if (ZERO_R0 && (bus.rd_addr_1 == '0))                  rd1_d = '0;
    if (busy)                                              rd1_d = '0;
  end

  always_comb begin
    rd2_d = regs_q[bus.rd_addr_2];
    if (BYPASS && wr_ok && (bus.wr_addr == bus.rd_addr_2)) rd2_d = bus.wr_data;
    if (ZERO_R0 && (bus.rd_addr_2 == '0))                  rd2_d = '0;
    if (busy)                                              rd2_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd1_q <= '0;
      rd2_q <= '0;
    end else begin
      rd1_q <= rd1_d;
      rd2_q <= rd2_d;
    end
  end

  assign bus.rd_data_1 = rd1_q;
  assign bus.rd_data_2 = rd2_q;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: three parameter variants driven in lockstep against an array-based model.
module tb_reg_file;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reg_file_if #(.DATA_W(8), .ADDR_W(4)) if0 ();
  reg_file_if #(.DATA_W(8), .ADDR_W(4)) if1 ();
  reg_file_if #(.DATA_W(8), .ADDR_W(4)) if2 ();

  reg_file #(.DATA_W(8), .ADDR_W(4), .BYPASS(1'b1), .ZERO_R0(1'b0)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  reg_file #(.DATA_W(8), .ADDR_W(4), .BYPASS(1'b0), .ZERO_R0(1'b0)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  reg_file #(.DATA_W(8), .ADDR_W(4), .BYPASS(1'b1), .ZERO_R0(1'b1)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));

  int tests = 0;
  int fails = 0;

  bit         byp  [3] = '{1'b1, 1'b0, 1'b1};
  bit         zr   [3] = '{1'b0, 1'b0, 1'b1};
  logic [7:0] mem  [3][16];
  int         left [3];

  task automatic chk(input string tag, input int d, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s dut%0d: got %h expected %h", tag, d, obs, exp);
    end
  endtask

  task automatic observe(input int d, output logic [7:0] r1, output logic [7:0] r2, output logic b);
    case (d)
      0:       begin r1 = if0.rd_data_1; r2 = if0.rd_data_2; b = if0.busy; end
      1:       begin r1 = if1.rd_data_1; r2 = if1.rd_data_2; b = if1.busy; end
      default: begin r1 = if2.rd_data_1; r2 = if2.rd_data_2; b = if2.busy; end
    endcase
  endtask

  task automatic drive(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                       input logic [3:0] a1, input logic [3:0] a2, input logic cr);
    if0.wr_en = we; if0.wr_addr = wa; if0.wr_data = wd; if0.rd_addr_1 = a1; if0.rd_addr_2 = a2; if0.clr_req = cr;
    if1.wr_en = we; if1.wr_addr = wa; if1.wr_data = wd; if1.rd_addr_1 = a1; if1.rd_addr_2 = a2; if1.clr_req = cr;
    if2.wr_en = we; if2.wr_addr = wa; if2.wr_data = wd; if2.rd_addr_1 = a1; if2.rd_addr_2 = a2; if2.clr_req = cr;
  endtask

  function automatic logic [7:0] model_rd(int d, logic acc, logic [3:0] wa, logic [7:0] wd, logic [3:0] a);
    if (zr[d] && a == 4'd0)          return 8'h00;
    if (byp[d] && acc && wa == a)    return wd;
    return mem[d][a];
  endfunction

  // One clock cycle: drive, advance past the edge, update model, compare all variants.
  task automatic step(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                      input logic [3:0] a1, input logic [3:0] a2, input logic cr);
    logic [7:0] e1, e2, r1, r2;
    logic       acc, b;
    drive(we, wa, wd, a1, a2, cr);
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      if (left[d] > 0) begin
        e1 = 8'h00; e2 = 8'h00;
        left[d]--;
        if (left[d] == 0) for (int i = 0; i < 16; i++) mem[d][i] = 8'h00;
      end else if (cr) begin
        e1 = model_rd(d, 1'b0, wa, wd, a1);
        e2 = model_rd(d, 1'b0, wa, wd, a2);
        left[d] = 16;
      end else begin
        acc = we && !(zr[d] && wa == 4'd0);
        e1 = model_rd(d, acc, wa, wd, a1);
        e2 = model_rd(d, acc, wa, wd, a2);
        if (acc) mem[d][wa] = wd;
      end
      observe(d, r1, r2, b);
      chk("rd_data_1", d, r1, e1);
      chk("rd_data_2", d, r2, e2);
      chk("busy", d, {7'b0, b}, {7'b0, left[d] > 0});
    end
  endtask

  task automatic reset_check(input string tag);
    logic [7:0] r1, r2;
    logic       b;
    for (int d = 0; d < 3; d++) begin
      observe(d, r1, r2, b);
      chk({tag, "_rd1"}, d, r1, 8'h00);
      chk({tag, "_rd2"}, d, r2, 8'h00);
      chk({tag, "_busy"}, d, {7'b0, b}, 8'h01);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    reset_check("rst_async");
    repeat (2) begin
      @(posedge clk);
      #1;
      reset_check("rst_hold");
    end
    rst = 1'b0;
    for (int d = 0; d < 3; d++) left[d] = 16;
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i += 2) step(1'b0, 4'd0, 8'h00, 4'(i), 4'(i + 1), 1'b0);
    step(1'b0, 4'd0, 8'h00, 4'd0, 4'd0, 1'b0);
  endtask

  initial begin
    drive(1'b0, 4'd0, 8'h00, 4'd0, 4'd0, 1'b0);
    for (int d = 0; d < 3; d++) begin
      left[d] = 0;
      for (int i = 0; i < 16; i++) mem[d][i] = 8'h00;
    end

    // Reset, sweep with addr 5 being read, then everything reads zero.
    do_reset();
    repeat (16) step(1'b0, 4'd0, 8'h00, 4'd5, 4'd5, 1'b0);
    read_all();

    // Basic write/read and dual-port same-address read.
    step(1'b1, 4'd0, 8'h0A, 4'd7, 4'd8, 1'b0);
    step(1'b1, 4'd1, 8'hA9, 4'd2, 4'd0, 1'b0);
    step(1'b0, 4'd0, 8'h00, 4'd0, 4'd1, 1'b0);
    step(1'b0, 4'd0, 8'h00, 4'd1, 4'd1, 1'b0);

    // Same-cycle write/read of addr 3: bypass vs old contents.
    step(1'b1, 4'd3, 8'h5C, 4'd3, 4'd3, 1'b0);
    step(1'b0, 4'd0, 8'h00, 4'd3, 4'd3, 1'b0);

    // Hard-zero r0 and a normal register on the same instances.
    step(1'b1, 4'd0, 8'hFF, 4'd0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 8'h00, 4'd0, 4'd0, 1'b0);
    step(1'b1, 4'd2, 8'h42, 4'd2, 4'd0, 1'b0);
    step(1'b0, 4'd0, 8'h00, 4'd2, 4'd2, 1'b0);

    // Fill, then clear together with a write that must be dropped; re-request mid-sweep.
    for (int i = 1; i < 16; i++) step(1'b1, 4'(i), 8'(8'h10 + i), 4'(i), 4'(i - 1), 1'b0);
    step(1'b1, 4'd4, 8'h77, 4'd4, 4'd5, 1'b1);
    for (int k = 0; k < 16; k++) step(1'b1, 4'd4, 8'h77, 4'd4, 4'd6, k == 5);
    read_all();

    // Reset at sweep cycle 7 restarts the full sweep.
    for (int i = 0; i < 16; i++) step(1'b1, 4'(i), 8'(8'hC0 + i), 4'(i), 4'(i), 1'b0);
    step(1'b0, 4'd0, 8'h00, 4'd1, 4'd2, 1'b1);
    repeat (7) step(1'b0, 4'd0, 8'h00, 4'd1, 4'd2, 1'b0);
    do_reset();
    repeat (16) step(1'b1, 4'd9, 8'h99, 4'd9, 4'd9, 1'b0);
    read_all();

    // Randomised traffic with occasional clear requests.
    repeat (400) begin
      step(1'($urandom_range(1)), 4'($urandom), 8'($urandom),
           4'($urandom), 4'($urandom), $urandom_range(39) == 0);
    end
    read_all();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
